// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between the
// instruction-fetch port and the load/store data port. Requests are
// arbitrated round-robin, and only one transaction is in flight at a time.
// Each transaction is sequenced IDLE -> ISSUE -> WAIT -> RESP.
//
// Handshake: a requester holds *_req_i high until it sees *_gnt_o high in
// the same cycle. The grant is combinational and lasts one cycle. It is only
// given in IDLE. The response is a one-cycle *_rvalid_o pulse, and
// *_rdata_o then holds until the next response to that port. Dropping req
// before the grant withdraws the request with no side effect.
module mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  // instruction-fetch port
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  // load/store data port
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  // memory macro side
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int BE_W = DATA_W / 8;

  // Elaboration-time parameter sanity checks
  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT must be in 1..7");
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("mem_arbiter: DATA_W must be a multiple of 8");
  end

  localparam logic [2:0] LAT_CNT = 3'(MEM_LAT);

  // Owner encoding: also records who won the most recent grant
  localparam logic WIN_IF = 1'b0;
  localparam logic WIN_D  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // All controller state lives in one struct, so a checker can bind to
  // ctl_q and see the FSM state, latency counter and owner together.
  typedef struct packed {
    state_t     state;
    logic [2:0] cnt;          // remaining latency cycles while in WAIT
    logic       last_winner;  // owner of the current/last transaction
  } ctl_t;

  ctl_t ctl_q;
  ctl_t ctl_d;

  // Registered transaction fields for the access being sequenced
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  // Round-robin pick: a lone requester wins, and a tie goes to the port
  // that did not win last time.
  logic pick_if;
  logic pick_d;
  assign pick_if = if_req_i && (!d_req_i || (ctl_q.last_winner == WIN_D));
  assign pick_d  = d_req_i  && (!if_req_i || (ctl_q.last_winner == WIN_IF));

  // The capture cycle is the WAIT cycle where the counter reads 1, which is
  // MEM_LAT cycles after the ISSUE cycle.
  logic capture;
  assign capture = (ctl_q.state == S_WAIT) && (ctl_q.cnt == 3'd1);

  // State register: FSM state, latency counter and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ctl_q.state       <= S_IDLE;
      ctl_q.cnt         <= 3'd0;
      ctl_q.last_winner <= WIN_D;
    end else begin
      ctl_q <= ctl_d;
    end
  end

  // Next-state logic: sequence one transaction at a time
  always_comb begin
    ctl_d = ctl_q;
    unique case (ctl_q.state)
      S_IDLE: begin
        if (pick_if || pick_d) begin
          ctl_d.state       = S_ISSUE;
          ctl_d.last_winner = pick_d ? WIN_D : WIN_IF;
        end
      end
      S_ISSUE: begin
        ctl_d.cnt   = LAT_CNT;
        ctl_d.state = S_WAIT;
      end
      S_WAIT: begin
        ctl_d.cnt = ctl_q.cnt - 3'd1;
        if (ctl_q.cnt == 3'd1) begin
          ctl_d.state = S_RESP;
        end
      end
      S_RESP: begin
        ctl_d.state = S_IDLE;
      end
      default: begin
        ctl_d.state = S_IDLE;
      end
    endcase
  end

  // Output logic: grants in IDLE, the memory strobe in ISSUE, rvalid in RESP
  always_comb begin
    if_gnt_o    = 1'b0;
    d_gnt_o     = 1'b0;
    if_rvalid_o = 1'b0;
    d_rvalid_o  = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    unique case (ctl_q.state)
      S_IDLE: begin
        // No grant while reset is asserted: the transaction would be lost.
        if_gnt_o = pick_if && !reset_i;
        d_gnt_o  = pick_d  && !reset_i;
      end
      S_ISSUE: begin
        mem_en_o = 1'b1;
        mem_we_o = we_q;
        mem_be_o = be_q;
      end
      S_RESP: begin
        if_rvalid_o = (ctl_q.last_winner == WIN_IF);
        d_rvalid_o  = (ctl_q.last_winner == WIN_D);
      end
      default: begin
      end
    endcase
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;

  // Datapath: latch the winner's request on the grant, and capture the
  // response data for the owner.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (ctl_q.state == S_IDLE && pick_d) begin
        addr_q  <= d_addr_i;
        we_q    <= d_we_i;
        // Reads always present all byte lanes to the memory
        be_q    <= d_we_i ? d_be_i : {BE_W{1'b1}};
        wdata_q <= d_we_i ? d_wdata_i : '0;
      end else if (ctl_q.state == S_IDLE && pick_if) begin
        addr_q  <= if_addr_i;
        we_q    <= 1'b0;
        be_q    <= {BE_W{1'b1}};
        wdata_q <= '0;
      end
      if (capture) begin
        if (ctl_q.last_winner == WIN_D) begin
          // A write completes with zero data on the data port
          d_rdata_q <= we_q ? '0 : mem_rdata_i;
        end else begin
          if_rdata_q <= mem_rdata_i;
        end
      end
    end
  end

  // Interface invariants
  a_gnt_excl: assert property (@(posedge clk_i) disable iff (reset_i)
    !(if_gnt_o && d_gnt_o));
  a_rvalid_excl: assert property (@(posedge clk_i) disable iff (reset_i)
    !(if_rvalid_o && d_rvalid_o));
  a_en_in_issue: assert property (@(posedge clk_i) disable iff (reset_i)
    mem_en_o |-> (ctl_q.state == S_ISSUE));
  a_quiet_strobe: assert property (@(posedge clk_i) disable iff (reset_i)
    !mem_en_o |-> (!mem_we_o && (mem_be_o == '0)));
  a_gnt_then_issue: assert property (@(posedge clk_i) disable iff (reset_i)
    (if_gnt_o || d_gnt_o) |=> mem_en_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. It uses one instance with
// MEM_LAT=1 (u_dut1) and one with MEM_LAT=3 (u_dut3), each paired with a
// small memory model. Read data is only correct in the exact cycle the
// arbiter should sample it.
module tb_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 1 (MEM_LAT = 1) ----------------
  logic        rst1, if_req1, if_gnt1, if_rvalid1;
  logic [11:0] if_addr1;
  logic [31:0] if_rdata1;
  logic        d_req1, d_we1, d_gnt1, d_rvalid1;
  logic [11:0] d_addr1;
  logic [31:0] d_wdata1, d_rdata1;
  logic [3:0]  d_be1;
  logic        mem_en1, mem_we1;
  logic [3:0]  mem_be1;
  logic [11:0] mem_addr1;
  logic [31:0] mem_wdata1, mem_rdata1;

  mem_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk_i(clk), .reset_i(rst1),
    .if_req_i(if_req1), .if_addr_i(if_addr1), .if_gnt_o(if_gnt1),
    .if_rvalid_o(if_rvalid1), .if_rdata_o(if_rdata1),
    .d_req_i(d_req1), .d_we_i(d_we1), .d_addr_i(d_addr1),
    .d_wdata_i(d_wdata1), .d_be_i(d_be1), .d_gnt_o(d_gnt1),
    .d_rvalid_o(d_rvalid1), .d_rdata_o(d_rdata1),
    .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_be_o(mem_be1),
    .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1), .mem_rdata_i(mem_rdata1)
  );

  // Memory model 1: full array with byte-enabled writes and a one-cycle read
  // pipe. Cycles with no read return junk.
  logic [31:0] mem1 [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) mem1[i] = {20'hC0DE0, 12'(i)};
    mem1[12'h010] = 32'hDEADBEEF;
    mem1[12'h0FF] = 32'hAABBCCDD;
  end
  always @(posedge clk) begin
    if (mem_en1 && mem_we1) begin
      for (int b = 0; b < 4; b++)
        if (mem_be1[b]) mem1[mem_addr1][8*b +: 8] <= mem_wdata1[8*b +: 8];
    end
    mem_rdata1 <= (mem_en1 && !mem_we1) ? mem1[mem_addr1] : {16'hBAD1, cyc[15:0]};
  end

  // ---------------- DUT 3 (MEM_LAT = 3) ----------------
  logic        rst3, if_req3, if_gnt3, if_rvalid3;
  logic [11:0] if_addr3;
  logic [31:0] if_rdata3;
  logic        d_req3, d_we3, d_gnt3, d_rvalid3;
  logic [11:0] d_addr3;
  logic [31:0] d_wdata3, d_rdata3;
  logic [3:0]  d_be3;
  logic        mem_en3, mem_we3;
  logic [3:0]  mem_be3;
  logic [11:0] mem_addr3;
  logic [31:0] mem_wdata3, mem_rdata3;

  mem_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk_i(clk), .reset_i(rst3),
    .if_req_i(if_req3), .if_addr_i(if_addr3), .if_gnt_o(if_gnt3),
    .if_rvalid_o(if_rvalid3), .if_rdata_o(if_rdata3),
    .d_req_i(d_req3), .d_we_i(d_we3), .d_addr_i(d_addr3),
    .d_wdata_i(d_wdata3), .d_be_i(d_be3), .d_gnt_o(d_gnt3),
    .d_rvalid_o(d_rvalid3), .d_rdata_o(d_rdata3),
    .mem_en_o(mem_en3), .mem_we_o(mem_we3), .mem_be_o(mem_be3),
    .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3), .mem_rdata_i(mem_rdata3)
  );

  // Memory model 3: data = 0x30000000 | addr, presented three cycles after
  // the strobe.
  logic [31:0] pipe3 [0:2];
  always @(posedge clk) begin
    pipe3[0] <= (mem_en3 && !mem_we3) ? {20'h30000, mem_addr3} : {16'hBAD3, cyc[15:0]};
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_rdata3 = pipe3[2];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] outs1();
    outs1 = '0;
    outs1[117:0] = {if_gnt1, if_rvalid1, if_rdata1, d_gnt1, d_rvalid1, d_rdata1,
                    mem_en1, mem_we1, mem_be1, mem_addr1, mem_wdata1};
  endfunction

  function automatic logic [127:0] outs3();
    outs3 = '0;
    outs3[117:0] = {if_gnt3, if_rvalid3, if_rdata3, d_gnt3, d_rvalid3, d_rdata3,
                    mem_en3, mem_we3, mem_be3, mem_addr3, mem_wdata3};
  endfunction

  // Scoreboard for u_dut1: {port (10 = fetch, 01 = data), rdata} per grant
  logic [33:0] exp_q[$];
  logic [33:0] sb_e;
  always @(negedge clk) begin
    if (!rst1 && (if_rvalid1 || d_rvalid1)) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_rvalid", exp_q.size(), 1);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_port", {if_rvalid1, d_rvalid1}, sb_e[33:32]);
        check("sb_data", d_rvalid1 ? d_rdata1 : if_rdata1, sb_e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // One isolated transaction on u_dut1. It starts from IDLE and returns in
  // the RESP cycle.
  task automatic run_one(input string tag, input logic is_d, input logic we,
                         input logic [11:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp_rd);
    logic [3:0] exp_be;
    logic [1:0] port;
    exp_be = we ? be : 4'hF;
    port   = is_d ? 2'b01 : 2'b10;
    step();
    if (is_d) begin
      d_req1 = 1'b1; d_we1 = we; d_addr1 = addr; d_wdata1 = wdata; d_be1 = be;
    end else begin
      if_req1 = 1'b1; if_addr1 = addr;
    end
    sample();
    check({tag, "_gnt"}, {if_gnt1, d_gnt1}, port);
    exp_q.push_back({port, exp_rd});
    step();
    if_req1 = 1'b0; d_req1 = 1'b0;
    sample();
    check({tag, "_issue"}, {mem_en1, mem_we1, mem_be1, mem_addr1}, {1'b1, we, exp_be, addr});
    if (we) check({tag, "_wdata"}, mem_wdata1, wdata);
    step();
    sample();
    check({tag, "_wait_quiet"}, {mem_en1, mem_we1, mem_be1, if_rvalid1, d_rvalid1, if_gnt1, d_gnt1}, 0);
    step();
    sample();
    check({tag, "_rvalid"}, {if_rvalid1, d_rvalid1}, port);
    check({tag, "_rdata"}, is_d ? d_rdata1 : if_rdata1, exp_rd);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] pat;
    rst1 = 1'b1; if_req1 = 1'b0; if_addr1 = '0; d_req1 = 1'b0; d_we1 = 1'b0;
    d_addr1 = '0; d_wdata1 = '0; d_be1 = '0;
    rst3 = 1'b1; if_req3 = 1'b0; if_addr3 = '0; d_req3 = 1'b0; d_we3 = 1'b0;
    d_addr3 = '0; d_wdata3 = '0; d_be3 = '0;

    // Reset state
    step(); step(); step();
    sample();
    check("rst1_outs", outs1(), 0);
    check("rst3_outs", outs3(), 0);
    step();
    rst1 = 1'b0; rst3 = 1'b0;
    sample();
    check("rst1_outs_rel", outs1(), 0);

    // Single fetch, MEM_LAT=1
    run_one("fetch", 1'b0, 1'b0, 12'h010, 32'h0, 4'h0, 32'hDEADBEEF);
    check("fetch_d_quiet", {d_gnt1, d_rvalid1, d_rdata1}, 0);

    // Byte-enabled write, then read back the merged word
    run_one("write", 1'b1, 1'b1, 12'h0FF, 32'h12345678, 4'b0101, 32'h0);
    run_one("rdback", 1'b1, 1'b0, 12'h0FF, 32'h0, 4'b0011, 32'hAA34CC78);

    // Persistent contention from reset release: I, D, I, D, 4 cycles apart
    step();
    rst1 = 1'b1;
    if_req1 = 1'b1; if_addr1 = 12'h020;
    d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 12'h030; d_be1 = 4'hF;
    sample();
    check("cont_no_gnt_in_rst", {if_gnt1, d_gnt1}, 0);
    step();
    rst1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      sample();
      pat = (k % 4 != 0) ? 2'b00 : (((k / 4) % 2 == 0) ? 2'b10 : 2'b01);
      check($sformatf("cont_gnt_%0d", k), {if_gnt1, d_gnt1}, pat);
      if (pat == 2'b10) exp_q.push_back({2'b10, 32'hC0DE0020});
      if (pat == 2'b01) exp_q.push_back({2'b01, 32'hC0DE0030});
      step();
    end
    if_req1 = 1'b0; d_req1 = 1'b0;

    // Data request raised during a fetch and withdrawn before IDLE
    step();
    if_req1 = 1'b1; if_addr1 = 12'h040;
    sample();
    check("wd_fetch_gnt", {if_gnt1, d_gnt1}, 2'b10);
    exp_q.push_back({2'b10, 32'hC0DE0040});
    step();
    if_req1 = 1'b0;
    sample();
    step();
    d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 12'h050;
    sample();
    check("wd_no_gnt_wait", d_gnt1, 0);
    step();
    d_req1 = 1'b0;
    sample();
    check("wd_resp", {if_rvalid1, d_gnt1}, 2'b10);
    for (int k = 0; k < 6; k++) begin
      step();
      sample();
      check($sformatf("wd_quiet_%0d", k), {d_gnt1, d_rvalid1, mem_en1}, 0);
    end

    // MEM_LAT=3 read on u_dut3; a fetch raised at T+1 waits until T+6
    step();
    d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 12'h123; d_be3 = 4'hF;
    sample();
    check("lat3_gnt", {if_gnt3, d_gnt3}, 2'b01);
    step();
    d_req3 = 1'b0; if_req3 = 1'b1; if_addr3 = 12'h200;
    sample();
    check("lat3_issue", {mem_en3, mem_be3, mem_addr3, if_gnt3}, {1'b1, 4'hF, 12'h123, 1'b0});
    for (int k = 2; k <= 5; k++) begin
      step();
      sample();
      check($sformatf("lat3_nognt_%0d", k), if_gnt3, 0);
      check($sformatf("lat3_rvalid_%0d", k), d_rvalid3, (k == 5));
      if (k == 5) check("lat3_rdata", d_rdata3, 32'h30000123);
    end
    step();
    sample();
    check("lat3_gnt_t6", {if_gnt3, d_gnt3}, 2'b10);

    // Reset during WAIT of that fetch
    step();
    if_req3 = 1'b0;
    sample();
    check("rw_issue", mem_en3, 1);
    step();
    rst3 = 1'b1;
    sample();
    step();
    rst3 = 1'b0;
    sample();
    check("rw_outs_zero", outs3(), 0);
    step();
    if_req3 = 1'b1; d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 12'h124;
    for (int k = 0; k <= 6; k++) begin
      sample();
      pat = (k == 0) ? 2'b10 : ((k == 6) ? 2'b01 : 2'b00);
      check($sformatf("rw_gnt_%0d", k), {if_gnt3, d_gnt3}, pat);
      check($sformatf("rw_rvalid_%0d", k), {if_rvalid3, d_rvalid3}, (k == 5) ? 2'b10 : 2'b00);
      if (k == 5) check("rw_rdata", if_rdata3, 32'h30000200);
      if (k < 6) step();
    end
    step();
    if_req3 = 1'b0; d_req3 = 1'b0;

    for (int k = 0; k < 8; k++) step();
    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles at most
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port synchronous memory between the core's instruction-fetch port and its load/store data port. It round-robin arbitrates between the two requesters and sequences each access through issue, latency wait and response. It returns read data, or a write acknowledge, to the winning port. It sits between the RISC-V core and the memory macro inside `top`, one transaction in flight at a time.

## Interface
Parameters:
- ADDR_W, 12, word-address width
- DATA_W, 32, data width; must be a multiple of 8
- MEM_LAT, 1, memory read latency in cycles from the `mem_en_o` cycle to valid `mem_rdata_i`; legal range 1..7

Ports:
- clk_i  in  1  clock; all logic on the rising edge
- reset_i  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request; held until granted
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  one-cycle pulse; `if_rdata_o` valid
- if_rdata_o  out  DATA_W  fetch read data
- d_req_i  in  1  data request; held until granted
- d_we_i  in  1  1 = write, 0 = read
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  write data
- d_be_i  in  DATA_W/8  byte enables for writes
- d_gnt_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  one-cycle pulse; read data valid, or write done
- d_rdata_o  out  DATA_W  data read data; 0 for a write
- mem_en_o  out  1  memory access strobe, one cycle per transaction
- mem_we_o  out  1  memory write enable
- mem_be_o  out  DATA_W/8  memory byte enables; all ones for reads
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid MEM_LAT cycles after `mem_en_o`

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - With no request, stay in IDLE.
  - With one request, grant it.
  - With both requests, grant the port that was *not* granted last.
  - `last_winner` resets to DATA, so fetch wins the first tie.
  - The grant is combinational from `*_req_i` and the state, and lasts one cycle.
  - On the grant cycle, register the winner's address, we, be and wdata, update `last_winner`, and go to ISSUE.
  - Fetch is always a read with be = all ones.
- **ISSUE:** drive `mem_en_o` = 1 plus the registered `mem_we_o`, `mem_be_o`, `mem_addr_o` and `mem_wdata_o` for exactly one cycle. Load the latency counter with MEM_LAT, then go to WAIT.
- **WAIT:**
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, which is MEM_LAT cycles after ISSUE, capture `mem_rdata_i` (or 0 for a write) into the owner's rdata register, then go to RESP.
- **RESP:** pulse `rvalid_o` of the owning port for one cycle, then go to IDLE.
- `rdata_o` holds its value until the next response to that port.
- Grant outside IDLE is never asserted; a requester keeps `req_i` high and waits.
- A requester that drops `req_i` before its grant is simply not served; this is not an error.
- **Reset:** applies from any state. The FSM goes to IDLE, the in-flight transaction is discarded with no rvalid, the counter is cleared and `last_winner` is set to DATA.

## Timing
- **Reset values:** every output is 0, including both `rdata_o`, `mem_addr_o`, `mem_wdata_o` and `mem_be_o`.
- **Transaction timeline:** grant at cycle T; `mem_en_o` at T+1; `mem_rdata_i` sampled at T+1+MEM_LAT; `rvalid_o` at T+2+MEM_LAT; FSM back in IDLE at T+3+MEM_LAT.
- **Throughput:** the earliest next grant is T+3+MEM_LAT, so with MEM_LAT=1 the arbiter completes one transaction every 4 cycles.
- **Mutual exclusion:** `if_gnt_o` and `d_gnt_o` are never high together. `if_rvalid_o` and `d_rvalid_o` are never high together.
- **Memory strobe:** `mem_en_o` is high only in ISSUE. `mem_we_o` and `mem_be_o` are 0 whenever `mem_en_o` = 0.
- **Write completion:** a write completes with `d_rvalid_o` at the same cycle offset as a read, with `d_rdata_o` = 0.
- **Request sampling:** a request arriving in RESP is not seen until the following IDLE cycle.

## Test plan
- **Single fetch, MEM_LAT=1.**
  - Stimulus: `if_req_i`=1, `if_addr_i`=0x010, memory returns 0xDEADBEEF.
  - Required: `if_gnt_o` at T; `mem_en_o`/`mem_addr_o`=0x010 at T+1; `if_rvalid_o`=1 with `if_rdata_o`=0xDEADBEEF at T+3; `d_*` outputs quiet throughout.
- **Persistent contention.**
  - Stimulus: both requests held high from reset release.
  - Required: grant order is I, D, I, D; grants 4 cycles apart; exactly one rvalid per grant.
- **Byte-enabled write.**
  - Stimulus: `d_we_i`=1, `d_addr_i`=0x0FF, `d_wdata_i`=0x12345678, `d_be_i`=4'b0101.
  - Required: at T+1, `mem_we_o`=1, `mem_be_o`=0101 and `mem_wdata_o`=0x12345678; `d_rvalid_o` at T+3 with `d_rdata_o`=0.
- **MEM_LAT=3 read.**
  - Required: memory data is presented at T+4 and `d_rvalid_o` follows at T+5.
  - Required: no grant to a request raised at T+1 until T+6.
- **Reset in WAIT.**
  - Stimulus: assert `reset_i` for one cycle during WAIT with MEM_LAT=3.
  - Required: no rvalid; all outputs 0 the cycle after reset.
  - Required: with both requests then held, the first grant goes to fetch.
- **Request withdrawn.**
  - Stimulus: raise `d_req_i` during WAIT of a fetch, then drop it before IDLE.
  - Required: no `d_gnt_o` and no data transaction.
